load_store_unit: RTL and testbench

Parametrised load/store unit for the multicycle RV32 core. It replaces the hard-wired word memory access with a valid/ready request port from the core FSM and a byte-enable memory bus. It handles LB/LH/LW/LBU/LHU/SB/SH/SW lane steering, sign/zero extension, misalignment detection and a bus timeout. The core FSM issues one request per instruction and stalls in its memory state until resp_valid.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready core request port to a byte-enable memory bus with lane steering,
// load extension, misalignment detection and bus timeout. Define LSU_PERF_CNT_EN to add perf counters.
module load_store_unit #(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [WORD_SIZE-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [WORD_SIZE-1:0]    resp_rdata,
  output logic [1:0]              resp_error,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WORD_SIZE/8-1:0]  mem_be,
  output logic [WORD_SIZE-1:0]    mem_wdata,
  input  logic [WORD_SIZE-1:0]    mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]             load_count,
  output logic [31:0]             store_count,
  output logic [31:0]             error_count
`endif
);
  localparam int NB = WORD_SIZE / 8;
  localparam int OW = $clog2(NB);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                 state;
  logic [OW-1:0]          off_q;
  logic [1:0]             size_q;
  logic                   uns_q, wr_q;
  logic [WORD_SIZE-1:0]   data_q;
  logic [1:0]             err_q;
  logic [TW-1:0]          tcnt;

  logic [OW-1:0] req_off;
  logic [2:0]    align_mask;
  logic          req_illegal, req_misaligned, tmo_hit;

  function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
    for (int i = 0; i < NB; i++) size_mask[i] = (i < (1 << sz));
  endfunction

  // Sign comes from the top bit of the accessed item; bits above it are filled with it.
  function automatic logic [WORD_SIZE-1:0] extend(input logic [WORD_SIZE-1:0] s,
                                                  input logic [1:0] sz, input logic uns);
    int   nbits;
    logic sign;
    nbits = 8 << sz;
    sign  = 1'b0;
    for (int i = 0; i < WORD_SIZE; i++) if (i == nbits - 1) sign = s[i] & ~uns;
    for (int i = 0; i < WORD_SIZE; i++) extend[i] = (i < nbits) ? s[i] : sign;
  endfunction

  assign req_off        = req_addr[OW-1:0];
  assign align_mask     = (3'd1 << req_size) - 3'd1;
  assign req_illegal    = (req_size == 2'b11) && (WORD_SIZE != 64);
  assign req_misaligned = |(req_addr[2:0] & align_mask);
  // A completion in the expiry cycle is checked first, so it wins over the timeout.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (({1'b0, tcnt} + (TW+1)'(1)) == (TW+1)'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 2'b00;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      off_q      <= '0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      err_q      <= 2'b00;
      tcnt       <= '0;
`ifdef LSU_PERF_CNT_EN
      load_count  <= '0;
      store_count <= '0;
      error_count <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          off_q     <= req_off;
          size_q    <= req_size;
          uns_q     <= req_unsigned;
          wr_q      <= req_write;
          data_q    <= '0;
          tcnt      <= '0;
          req_ready <= 1'b0;
          if (req_illegal) begin
            err_q <= 2'b11;
            state <= DONE;
          end else if (req_misaligned) begin
            err_q <= 2'b01;
            state <= DONE;
          end else begin
            err_q     <= 2'b00;
            state     <= WAIT;
            mem_valid <= 1'b1;
            mem_write <= req_write;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            mem_be    <= size_mask(req_size) << req_off;
            mem_wdata <= req_wdata << {req_off, 3'b000};
          end
        end
        WAIT: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (!wr_q) data_q <= extend(mem_rdata >> {off_q, 3'b000}, size_q, uns_q);
            state <= DONE;
          end else if (tmo_hit) begin
            mem_valid <= 1'b0;
            err_q     <= 2'b10;
            state     <= DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DONE: begin
          resp_valid <= 1'b1;
          resp_rdata <= data_q;
          resp_error <= err_q;
          req_ready  <= 1'b1;
          state      <= IDLE;
`ifdef LSU_PERF_CNT_EN
          if (err_q != 2'b00) begin
            if (error_count != '1) error_count <= error_count + 32'd1;
          end else if (wr_q) begin
            if (store_count != '1) store_count <= store_count + 32'd1;
          end else begin
            if (load_count != '1) load_count <= load_count + 32'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (WORD_SIZE=32, TIMEOUT_CYCLES=4): directed test-plan cases plus random
// transactions, checked every cycle against a transaction-timeline model.
module tb_load_store_unit;
  localparam int T = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, mem_valid, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [1:0]  resp_error;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_count, store_count, error_count;
`endif

  load_store_unit #(.WORD_SIZE(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_PERF_CNT_EN
    , .load_count(load_count), .store_count(store_count), .error_count(error_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load result from the spec rules: shift the lane down, keep nb bytes, sign-fill unless unsigned.
  function automatic logic [31:0] m_load(input logic [31:0] word, input int off, input int nb,
                                         input logic uns);
    logic [63:0] v, m;
    v = {32'b0, word} >> (8 * off);
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v[31:0];
  endfunction

  // Timeline model: cycle numbers at which req_ready returns, mem_valid runs, resp_valid pulses.
  int          ready_at = 0, resp_at = -1, win_start = 0;
  bit          win_on = 0;
  logic        w_m = 0, u_m = 0;
  int          off_m = 0, nb_m = 1;
  logic [31:0] ea = '0, ewd = '0, p_rdata = '0, h_rdata = '0;
  logic [3:0]  ebe = '0;
  logic [1:0]  p_err = '0, h_err = '0;
  logic [31:0] lc = '0, sc = '0, ec = '0;
  bit          exp_mv;

  always @(negedge clk) begin
    if (!rst) begin
      ready_at = 0; resp_at = -1; win_on = 0; h_rdata = '0; h_err = '0;
      lc = '0; sc = '0; ec = '0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_error", resp_error, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end else begin
      if (cyc == resp_at) begin
        h_rdata = p_rdata;
        h_err   = p_err;
        if (p_err != 0) begin if (ec != '1) ec++; end
        else if (w_m) begin if (sc != '1) sc++; end
        else begin if (lc != '1) lc++; end
      end
      exp_mv = win_on && cyc >= win_start;
      chk("req_ready", req_ready, 64'(cyc >= ready_at));
      chk("resp_valid", resp_valid, 64'(cyc == resp_at));
      chk("resp_rdata", resp_rdata, h_rdata);
      chk("resp_error", resp_error, h_err);
      chk("mem_valid", mem_valid, 64'(exp_mv));
      if (exp_mv) begin
        chk("mem_addr", mem_addr, ea);
        chk("mem_be", mem_be, ebe);
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_write", mem_write, w_m);
      end
      if (exp_mv) begin
        if (mem_ready) begin
          win_on = 0; resp_at = cyc + 2; ready_at = resp_at; p_err = 2'b00;
          p_rdata = w_m ? 32'h0 : m_load(mem_rdata, off_m, nb_m, u_m);
        end else if (cyc - win_start + 1 == T) begin
          win_on = 0; resp_at = cyc + 2; ready_at = resp_at; p_err = 2'b10; p_rdata = '0;
        end
      end else if (req_valid && cyc >= ready_at) begin
        w_m = req_write; u_m = req_unsigned; nb_m = 1 << req_size; off_m = int'(req_addr[1:0]);
        if (req_size == 2'b11) begin
          resp_at = cyc + 2; ready_at = resp_at; p_err = 2'b11; p_rdata = '0;
        end else if (req_addr % nb_m != 0) begin
          resp_at = cyc + 2; ready_at = resp_at; p_err = 2'b01; p_rdata = '0;
        end else begin
          win_on = 1; win_start = cyc + 1; ready_at = 1 << 30;
          ea  = req_addr & ~32'h3;
          ebe = 4'(((1 << nb_m) - 1) << off_m);
          ewd = req_wdata << (8 * off_m);
        end
      end
`ifdef LSU_PERF_CNT_EN
      chk("load_count", load_count, lc);
      chk("store_count", store_count, sc);
      chk("error_count", error_count, ec);
`endif
    end
  end

  typedef struct {
    logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic wr;
    int mvcnt; logic rv; logic [31:0] rdata; logic [1:0] err;
  } obs_t;

  task automatic garbage();
    req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Called at posedge+1 of a cycle where the unit is ready; returns in the response cycle.
  // dly = WAIT cycles before mem_ready (>= T means never).
  task automatic txn(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int dly, output obs_t o);
    int k;
    bit e;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    @(posedge clk); #1;
    o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.wr = mem_write; o.mvcnt = 0;
    e = (sz == 2'b11) || ((a % (32'd1 << sz)) != 0);
    k = e ? 0 : ((dly < T) ? dly + 1 : T);
    for (int i = 0; i < k; i++) begin
      if (i > 0) garbage();
      else req_valid = 1'b0;
      mem_ready = (i == dly);
      mem_rdata = (i == dly) ? rd : $urandom;
      if (mem_valid) o.mvcnt++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_ready = 1'($urandom); mem_rdata = $urandom;
    if (mem_valid) o.mvcnt++;
    @(posedge clk); #1;
    o.rv = resp_valid; o.rdata = resp_rdata; o.err = resp_error;
  endtask

  initial begin
    obs_t o;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r, dly;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    txn(0, 2'b10, 0, 32'h104, 32'h0, 32'hDEADBEEF, 0, o);
    chk("lw_addr", o.addr, 32'h104);
    chk("lw_be", o.be, 4'b1111);
    chk("lw_mvcnt", o.mvcnt, 1);
    chk("lw_rv", o.rv, 1);
    chk("lw_rdata", o.rdata, 32'hDEADBEEF);
    chk("lw_err", o.err, 0);

    txn(0, 2'b00, 0, 32'h103, 32'h0, 32'h80123456, 1, o);
    chk("lb_be", o.be, 4'b1000);
    chk("lb_rdata", o.rdata, 32'hFFFFFF80);
    txn(0, 2'b00, 1, 32'h103, 32'h0, 32'h80123456, 0, o);
    chk("lbu_rdata", o.rdata, 32'h00000080);

    txn(1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h12345678, 0, o);
    chk("sh_addr", o.addr, 32'h200);
    chk("sh_be", o.be, 4'b1100);
    chk("sh_wdata", o.wdata, 32'hABCD0000);
    chk("sh_write", o.wr, 1);
    chk("sh_rdata", o.rdata, 0);

    txn(0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, o);
    chk("mis_mvcnt", o.mvcnt, 0);
    chk("mis_rv", o.rv, 1);
    chk("mis_err", o.err, 2'b01);
    txn(0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 0, o);
    chk("ill_err", o.err, 2'b11);

    txn(0, 2'b10, 0, 32'h400, 32'h0, 32'h55AA55AA, 9, o);
    chk("tmo_mvcnt", o.mvcnt, 4);
    chk("tmo_err", o.err, 2'b10);
    chk("tmo_rdata", o.rdata, 0);
    txn(0, 2'b10, 0, 32'h400, 32'h0, 32'h55AA55AA, 3, o);
    chk("late_ok_err", o.err, 2'b00);
    chk("late_ok_rdata", o.rdata, 32'h55AA55AA);

    // Reset while the bus cycle is outstanding.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h300; mem_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_resp_valid", resp_valid, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    txn(0, 2'b10, 0, 32'h308, 32'h0, 32'h0BADF00D, 1, o);
    chk("post_rst_rdata", o.rdata, 32'h0BADF00D);
    chk("post_rst_err", o.err, 0);
`ifdef LSU_PERF_CNT_EN
    chk("post_rst_load_count", load_count, 1);
`endif

    for (int n = 0; n < 300; n++) begin
      r   = int'($urandom % 16);
      sz  = (r == 0) ? 2'b11 : 2'(r % 3);
      a   = $urandom;
      if ($urandom % 4 != 0) a = a & ~((32'd1 << sz) - 32'd1);
      dly = ($urandom % 8 < 6) ? int'($urandom % 4) : 4 + int'($urandom % 3);
      txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, dly, o);
      repeat ($urandom % 3) begin
        req_valid = 1'b0; mem_ready = 1'($urandom); mem_rdata = $urandom;
        @(posedge clk); #1;
      end
    end

    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
